// File: rtl/ode_memory_responder.sv
// ode_memory_responder
// Responder side of the step engine's dual-read memory interface. Holds the
// x-vector and step words in a 2^ADDRESS_WIDTH x WORD_SIZE array, accepts host
// writes through a valid/ready handshake and serves two independent read
// ports with one cycle of latency. The array clears itself after reset and on
// a clear pulse, so the step engine never reads undefined contents.
//
// Optional feature: define ODE_MEMORY_WRITE_BYPASS_EN to forward wr_data to a
// read port that reads the address being written at the same edge. Without
// it, such a read returns the old word.
module ode_memory_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic [WORD_SIZE-1:0]     wr_data,
  input  logic                     rd_en1,
  input  logic [ADDRESS_WIDTH-1:0] rd_address1,
  output logic [WORD_SIZE-1:0]     rd_data1,
  output logic                     rd_valid1,
  input  logic                     rd_en2,
  input  logic [ADDRESS_WIDTH-1:0] rd_address2,
  output logic [WORD_SIZE-1:0]     rd_data2,
  output logic                     rd_valid2
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clear_count;
  logic [WORD_SIZE-1:0]     mem [DEPTH];

  logic                     read_open;
  logic                     write_accept;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_wa;
  logic [WORD_SIZE-1:0]     mem_wd;
  logic [WORD_SIZE-1:0]     read_word1;
  logic [WORD_SIZE-1:0]     read_word2;

  // Writes and reads are only serviced in IDLE and never in a cycle that
  // starts a clear; reset blocks any commit at the edge it is sampled.
  assign wr_ready     = (state == IDLE) & ~clear;
  assign read_open    = (state == IDLE) & ~clear;
  assign write_accept = wr_valid & wr_ready & ~rst;

  // Select the single array write: the clear sweep owns the port in CLEAR,
  // otherwise an accepted host write uses it.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_address;
    mem_wd = wr_data;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clear_count;
        mem_wd = '0;
      end else if (write_accept) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array storage; no reset so it maps onto plain RAM, the clear sweep
  // provides defined contents instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read word for each port, optionally forwarding a same-edge write.
  always_comb begin
    read_word1 = mem[rd_address1];
    read_word2 = mem[rd_address2];
`ifdef ODE_MEMORY_WRITE_BYPASS_EN
    if (write_accept && (wr_address == rd_address1)) begin
      read_word1 = wr_data;
    end
    if (write_accept && (wr_address == rd_address2)) begin
      read_word2 = wr_data;
    end
`endif
  end

  // Clear/idle sequencer: sweeps every address once, then waits in IDLE
  // until a clear pulse; reset always restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clear_count <= '0;
      busy        <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clear_count <= clear_count + 1'b1;
          if (clear_count == {ADDRESS_WIDTH{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear) begin
            state       <= CLEAR;
            clear_count <= '0;
            busy        <= 1'b1;
          end
        end
        default: begin
          state       <= CLEAR;
          clear_count <= '0;
          busy        <= 1'b1;
        end
      endcase
    end
  end

  // Registered read ports: data is zeroed whenever reads are blocked, and
  // held when the port is simply not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data1  <= '0;
      rd_valid1 <= 1'b0;
      rd_data2  <= '0;
      rd_valid2 <= 1'b0;
    end else if (!read_open) begin
      rd_data1  <= '0;
      rd_valid1 <= 1'b0;
      rd_data2  <= '0;
      rd_valid2 <= 1'b0;
    end else begin
      rd_valid1 <= rd_en1;
      rd_valid2 <= rd_en2;
      if (rd_en1) begin
        rd_data1 <= read_word1;
      end
      if (rd_en2) begin
        rd_data2 <= read_word2;
      end
    end
  end

endmodule

// File: tb/tb_ode_memory_responder.sv
// tb_ode_memory_responder
// Scoreboard bench: the stimulus task runs a behavioural model of the memory
// (an array plus a count of remaining clear cycles) and queues the expected
// read-port contents for each edge; a negedge monitor pops and compares.
module tb_ode_memory_responder;

  localparam int WS    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          busy;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_address;
  logic [WS-1:0] wr_data;
  logic          rd_en1;
  logic [AW-1:0] rd_address1;
  logic [WS-1:0] rd_data1;
  logic          rd_valid1;
  logic          rd_en2;
  logic [AW-1:0] rd_address2;
  logic [WS-1:0] rd_data2;
  logic          rd_valid2;

  always #5 clk = ~clk;

  ode_memory_responder #(.WORD_SIZE(WS), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_address(wr_address), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_address1(rd_address1),
    .rd_data1(rd_data1), .rd_valid1(rd_valid1),
    .rd_en2(rd_en2), .rd_address2(rd_address2),
    .rd_data2(rd_data2), .rd_valid2(rd_valid2)
  );

  typedef struct {
    int unsigned   edge_tag;
    logic          valid;
    logic          check_data;
    logic [WS-1:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int unsigned   edge_count = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  logic [WS-1:0] model_mem [DEPTH];
  int            clear_left = 0;
  bit            model_known = 0;
  logic [WS-1:0] last_data [2];
  bit            last_known [2];
  bit            last_accepted = 0;
  bit            bypass_en;

  // Edge counter used to tag scoreboard entries.
  always @(posedge clk) edge_count++;

  task automatic checkSignal(input string name, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, edge_count, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e, input logic v, input logic [WS-1:0] d);
    tests_run++;
    if (v !== e.valid) begin
      tests_failed++;
      $display("[TB] FAIL %s_valid at edge %0d: got %b, expected %b", name, edge_count, v, e.valid);
    end
    if (e.check_data) begin
      tests_run++;
      if (d !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL %s_data at edge %0d: got %h, expected %h", name, edge_count, d, e.data);
      end
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0 && q1[0].edge_tag == edge_count) begin
      e = q1.pop_front();
      checkOutput("rd_port1", e, rd_valid1, rd_data1);
    end
    if (q2.size() > 0 && q2[0].edge_tag == edge_count) begin
      e = q2.pop_front();
      checkOutput("rd_port2", e, rd_valid2, rd_data2);
    end
  end

  function automatic exp_t blockedRead(input int p, input logic en, input int unsigned tag);
    exp_t x;
    x.edge_tag   = tag;
    x.valid      = 1'b0;
    x.check_data = en;
    x.data       = '0;
    last_data[p]  = '0;
    last_known[p] = en;
    return x;
  endfunction

  function automatic exp_t openRead(input int p, input logic en, input logic [WS-1:0] word,
                                    input int unsigned tag);
    exp_t x;
    x.edge_tag = tag;
    x.valid    = en;
    if (en) begin
      x.check_data  = 1'b1;
      x.data        = word;
      last_data[p]  = word;
      last_known[p] = 1'b1;
    end else begin
      x.check_data = last_known[p];
      x.data       = last_data[p];
    end
    return x;
  endfunction

  // Behavioural model of one clock edge with the given inputs.
  task automatic modelEdge(input logic r, input logic c, input logic wv,
                           input logic [AW-1:0] wa, input logic [WS-1:0] wd,
                           input logic e1, input logic [AW-1:0] a1,
                           input logic e2, input logic [AW-1:0] a2);
    exp_t          x1, x2;
    logic [WS-1:0] w1, w2;
    int unsigned   tag = edge_count + 1;
    last_accepted = 0;
    if (r) begin
      model_known = 1;
      x1 = blockedRead(0, 1'b1, tag);
      x2 = blockedRead(1, 1'b1, tag);
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (clear_left > 0 || c) begin
      x1 = blockedRead(0, e1, tag);
      x2 = blockedRead(1, e2, tag);
      if (clear_left > 0) begin
        clear_left--;
      end else begin
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end
    end else begin
      w1 = (bypass_en && wv && wa == a1) ? wd : model_mem[a1];
      w2 = (bypass_en && wv && wa == a2) ? wd : model_mem[a2];
      x1 = openRead(0, e1, w1, tag);
      x2 = openRead(1, e2, w2, tag);
      if (wv) model_mem[wa] = wd;
      last_accepted = wv;
    end
    if (model_known) begin
      q1.push_back(x1);
      q2.push_back(x2);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic wv,
                               input logic [AW-1:0] wa, input logic [WS-1:0] wd,
                               input logic e1, input logic [AW-1:0] a1,
                               input logic e2, input logic [AW-1:0] a2);
    rst = r; clear = c; wr_valid = wv; wr_address = wa; wr_data = wd;
    rd_en1 = e1; rd_address1 = a1; rd_en2 = e2; rd_address2 = a2;
    #1;
    if (model_known) begin
      checkSignal("busy", busy, clear_left > 0);
      checkSignal("wr_ready", wr_ready, (clear_left == 0) && !c);
    end
    modelEdge(r, c, wv, wa, wd, e1, a1, e2, a2);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic          r, c, wv, e1, e2;
    logic [AW-1:0] wa, a1, a2;
    logic [WS-1:0] wd;
    int            n;
`ifdef ODE_MEMORY_WRITE_BYPASS_EN
    bypass_en = 1;
`else
    bypass_en = 0;
`endif
    last_data[0] = '0; last_data[1] = '0;
    last_known[0] = 0; last_known[1] = 0;
    #1;

    // Reset, full clear sweep, then read back every address.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(17);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, AW'(i), 1, AW'(DEPTH - 1 - i));

    // Two writes then a dual read.
    applyStimulus(0, 0, 1, 4'd3, 16'h1234, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 4'd9, 16'hBEEF, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd3, 1, 4'd9);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd9, 1, 4'd9);

    // Read-during-write to the same address, then a plain re-read.
    applyStimulus(0, 0, 1, 4'd5, 16'h00AA, 1, 4'd5, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd5, 1, 4'd5);
    idleCycles(1);

    // Clear together with a write: write refused, array cleared.
    applyStimulus(0, 0, 1, 4'd7, 16'h5555, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 4'd8, 16'h9999, 1, 4'd7, 0, 0);
    idleCycles(16);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd7, 1, 4'd8);

    // Reset in the middle of a clear restarts the sweep.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(17);

    // Write held through a clear is accepted on the first IDLE cycle.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    do begin
      applyStimulus(0, 0, 1, 4'd2, 16'h7777, 0, 0, 0, 0);
      n++;
    end while (!last_accepted && n < 40);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd2, 1, 4'd2);

    // Randomized traffic with occasional clears and resets.
    wv = 0; wa = 0; wd = 0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      if (!(wv && !last_accepted)) begin
        wv = ($urandom_range(0, 1) == 1);
        wa = AW'($urandom_range(0, DEPTH - 1));
        wd = WS'($urandom);
      end
      e1 = ($urandom_range(0, 9) < 6);
      e2 = ($urandom_range(0, 9) < 6);
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      applyStimulus(r, c, wv, wa, wd, e1, a1, e2, a2);
    end

    idleCycles(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ode_memory_responder.md
Name: ode_memory_responder

Overview:
- Responder side of the step engine's dual-read memory interface.
- Holds the x-vector and step words in a 2^ADDRESS_WIDTH x WORD_SIZE array and serves two independent read ports with registered data.
- Accepts host writes through a valid/ready handshake.
- Self-clears on reset and on request, so the step engine always reads defined contents.

Parameters:
- WORD_SIZE, 16, data word width in bits.
- ADDRESS_WIDTH, 4, address width; depth = 2^ADDRESS_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  pulse; starts a full clear of the array.
- busy  out  1  high while the clear sequence runs.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_address  in  ADDRESS_WIDTH  write address.
- wr_data  in  WORD_SIZE  write data.
- rd_en1  in  1  read request, port 1.
- rd_address1  in  ADDRESS_WIDTH  read address, port 1.
- rd_data1  out  WORD_SIZE  read data, port 1.
- rd_valid1  out  1  rd_data1 qualifier.
- rd_en2, rd_address2, rd_data2, rd_valid2: same as port 1, for port 2.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst`, synchronous and active-high.
- FSM states: CLEAR and IDLE.
- Reset:
  - Entered when rst is high at a clock edge; overrides everything, including mid-clear or mid-write.
  - State becomes CLEAR with the clear counter at 0.
  - rd_data1/2 = 0, rd_valid1/2 = 0, busy = 1, wr_ready = 0.
- CLEAR:
  - Each cycle writes 0 to array[counter], then increments counter.
  - After writing address 2^ADDRESS_WIDTH-1, goes to IDLE next edge. Total 2^ADDRESS_WIDTH cycles.
  - busy = 1 throughout.
  - A clear pulse during CLEAR is ignored; the sequence does not restart.
- IDLE:
  - busy = 0.
  - A clear pulse goes to CLEAR with counter = 0 on the next edge.
- wr_ready is combinational: (state == IDLE) & ~clear.
- Writes:
  - A write commits at an edge only when wr_valid & wr_ready.
  - No write is accepted in the cycle clear is asserted.
  - wr_address, wr_data must be stable while wr_valid is high and wr_ready is low.
- Reads:
  - Latency is 1 cycle.
  - If rd_enN is high at edge k in IDLE: rd_dataN = array[rd_addressN] and rd_validN = 1 after edge k.
  - If rd_enN is low: rd_validN = 0 and rd_dataN holds its last value.
  - Reads while in CLEAR, or in the cycle clear is asserted: rd_validN = 0 and rd_dataN = 0.
- Both ports may read the same address in the same cycle; both return identical data.
- Read-during-write to the same address without the optional feature: returns the old word; the new word is visible from the next read.
- Addresses are full-range; no out-of-range case exists and no error output.

Optional Feature:
- Macro: ODE_MEMORY_WRITE_BYPASS_EN.
- Defined: a read at the same edge as an accepted write to the same address returns wr_data (forwarding on each port independently).
- Undefined: the read returns the old array contents.
- Array timing is identical either way.

Test Plan:
- rst high 1 cycle, then low:
  - busy = 1 and wr_ready = 0 for exactly 16 cycles, then busy = 0.
  - Reading addresses 0..15 returns 0x0000 with rd_valid = 1 one cycle after each rd_en.
- Write 0x1234 to address 3, then 0xBEEF to address 9; next cycle rd_address1 = 3, rd_address2 = 9, both enables high -> one cycle later rd_data1 = 0x1234, rd_data2 = 0xBEEF, both valid.
- Write 0x00AA to address 5; same edge read address 5 on port 1 -> 0x0000 without the macro, 0x00AA with it; next read returns 0x00AA either way.
- After writing address 7 = 0x5555, pulse clear together with a wr_valid to address 8:
  - wr_ready = 0 and the write is not committed.
  - busy = 1 for 16 cycles.
  - Afterwards addresses 7 and 8 read 0x0000.
- Assert rst on the 6th cycle of a clear -> clear restarts from counter 0; busy stays high 16 more cycles.
- Hold wr_valid high during CLEAR with data 0x7777 at address 2 -> the write is accepted on the first IDLE cycle; address 2 then reads 0x7777.
